cpu_step_ctrl: RTL

Consumes the divided clock `clkout` from `clk_div` and produces a one-`clk`-cycle CPU clock-enable, `cpu_en`. It supports two modes: free-run, with one enable per divided-clock rising edge, and single-step, with one enable per debounced button press. It sits between `clk_div` and the CPU core and owns button debouncing, mode control and halt handling. Everything runs on the single fast clock; `slow_clk` is treated as data.

---
 rtl/cpu_step_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: free-run on every divided-clock rise, or
// single-step on each debounced button press, with a sticky halt.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int STEP_CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  slow_clk,
  input  logic                  btn_step,
  input  logic                  run_mode,
  input  logic                  halt,
  output logic                  tick,
  output logic                  cpu_en,
  output logic [STEP_CNT_W-1:0] step_cnt,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_TICKS - 1);

  logic       slow_s1, slow_clk_s, slow_prev;
  logic       btn_s1, btn_s;
  logic       run_s1, run_mode_s;
  logic       btn_db, press;
  logic [7:0] db_cnt;
  state_t     state;

  // NOTE: every sequential block uses non-blocking assignments so that all
  // flops sample pre-edge values, which is what makes the synchronizer
  // chains and the slow_prev edge detector behave as real shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_s1    <= 1'b0;
      slow_clk_s <= 1'b0;
      slow_prev  <= 1'b0;
      tick       <= 1'b0;
      btn_s1     <= 1'b0;
      btn_s      <= 1'b0;
      run_s1     <= 1'b0;
      run_mode_s <= 1'b0;
    end else begin
      slow_s1    <= slow_clk;
      slow_clk_s <= slow_s1;
      slow_prev  <= slow_clk_s;
      tick       <= slow_clk_s & ~slow_prev;
      btn_s1     <= btn_step;
      btn_s      <= btn_s1;
      run_s1     <= run_mode;
      run_mode_s <= run_s1;
    end
  end

  // Debounce samples only on ticks, so the filter window scales with the
  // divided clock rather than the fast clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (tick) begin
        if (btn_s != btn_db) begin
          if (db_cnt == DB_LAST) begin
            btn_db <= ~btn_db;
            db_cnt <= '0;
            press  <= ~btn_db;
          end else begin
            db_cnt <= db_cnt + 8'd1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cpu_en <= 1'b0;
    end else begin
      cpu_en <= 1'b0;
      if (halt) begin
        state <= HALTED;
      end else begin
        unique case (state)
          IDLE: begin
            // run_mode takes precedence; a coincident press is discarded.
            if (run_mode_s)  state <= RUN;
            else if (press)  state <= STEP;
          end
          RUN: begin
            if (!run_mode_s) state  <= IDLE;
            else if (tick)   cpu_en <= 1'b1;
          end
          STEP: begin
            if (tick) begin
              cpu_en <= 1'b1;
              state  <= IDLE;
            end
          end
          HALTED: state <= HALTED;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         step_cnt <= '0;
    else if (cpu_en) step_cnt <= step_cnt + STEP_CNT_W'(1);
  end

  assign state_dbg = state;

endmodule
